zzacc: RTL
==========

# zzacc

Zig-zag shift-accumulator; sits directly downstream of the zig-zag address generator and the bit-plane dot-product array. Each accepted beat carries one bit-plane partial sum together with the generator's shift flag. The block rebuilds the full-precision MSB-first dot product with `acc = (acc << sh) ± term`. It then hands the finished result to the output/quantizer stage over a valid/ready handshake, back-pressuring the generator when the output is blocked.

## Interface
Parameters:
- `BWIN`, 27, width of signed partial-sum input
- `BWACC`, 32, width of signed accumulator and result

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `clr`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  beat present
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `in_data`  in  BWIN  signed partial sum of one bit-plane pair
- `in_sh`  in  1  shift flag from generator, aligned with `in_data`
- `in_neg`  in  1  subtract term (sign-plane product)
- `in_last`  in  1  final beat of this multiplication
- `out_valid`  out  1  result register full
- `out_ready`  in  1  consumer takes result when `out_valid & out_ready`
- `out_data`  out  BWACC  signed result
- `out_ovf`  out  1  overflow occurred while forming `out_data`
- `busy`  out  1  state != IDLE or `out_valid`

## Operation
- States: IDLE (no beat of current multiplication yet), ACC (accumulating), HOLD (finished result parked in `acc`, output register full).
- `term` = `in_data` sign-extended to BWACC; negated if `in_neg`.
- IDLE, beat accepted: `acc <= term`; `in_sh` ignored; `ovf_acc <= 0`.
- ACC, beat accepted: `acc <= (in_sh ? acc<<1 : acc) + term`, computed in BWACC+2 bits, then reduced per Configuration. `ovf_acc` is sticky.
- Beat with `in_last`, output register free: `out_data`/`out_ovf` loaded with the new value; state returns to IDLE. The register is free when `!out_valid`, or when `out_valid & out_ready` in the same cycle.
- Beat with `in_last`, output register not free: new value stays in `acc`; state goes to HOLD.
- `in_ready` = state != HOLD.
- HOLD: when the output register frees, transfer `acc`→output and go to IDLE.
- Single-beat multiplication: a beat in IDLE with `in_last` goes straight out.
- Beats without `in_valid` leave all state unchanged. The generator's step is driven by `in_ready`.
- `clr`:
  - state←IDLE, `acc`←0, `ovf_acc`←0, `out_valid`←0, `out_data`←0, `out_ovf`←0.
  - Overrides any simultaneous beat or handshake.
  - A partially accumulated result is discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_ovf`=0, `busy`=0.
- Latency: `in_last` accepted at edge N → `out_valid`=1 after edge N.
- HOLD exit: output handshake at edge M → HOLD result appears in `out_data` after edge M; `in_ready` returns high after edge M.
- `out_valid` stays high and `out_data`/`out_ovf` stay stable until handshake.
- Throughput: one beat per cycle while not in HOLD; back-to-back multiplications with no bubble if `out_ready`=1.
- `in_ready` depends only on registered state; no combinational path from `out_ready`.

## Configuration
- `ZZACC_SAT_EN` defined:
  - Each accumulation step clamps to [-2^(BWACC-1), 2^(BWACC-1)-1].
  - Shift-out of significant bits also clamps.
  - `ovf_acc` set on any clamp.
- Undefined:
  - Two's-complement wrap to BWACC bits.
  - `ovf_acc` still set when the true value exceeds the range.
  - Result is the wrapped value.

## Test plan
- Basic: beats (3,sh0),(5,sh1),(-2,sh1,last), `out_ready`=1 → `out_valid` after the last beat's edge, `out_data`=20, `out_ovf`=0.
- Negate: beats (4),(3,sh1,neg,last) → `out_data`=5.
- Back-pressure: `out_ready`=0, two 2-beat multiplications giving 7 then 9:
  - 7 held in output, 9 in HOLD, `in_ready`=0.
  - Raise `out_ready` one cycle → `out_data`=9 next cycle, `in_ready`=1.
- Overflow, BWACC=8: beats (100),(100,sh1,last):
  - Without macro: `out_data`=44, `out_ovf`=1.
  - With `ZZACC_SAT_EN`: `out_data`=127, `out_ovf`=1.
- Reset mid-op: two beats of an unfinished multiplication, `clr` one cycle with `in_valid`=1 → all outputs at reset values. Next multiplication (6,last) gives `out_data`=6.
- Single-beat plus simultaneous events: `out_valid` held and `out_ready`=1 in the same cycle as a last beat (-1,last) → no HOLD, `out_data`=-1 next cycle.

Source files
------------

// File: rtl/zzacc.sv
// rtl/zzacc.sv - zig-zag shift-accumulator with valid/ready result register
//
// Rebuilds an MSB-first dot product from bit-plane partial sums:
//   acc = (in_sh ? acc << 1 : acc) +/- term
// and hands the finished result downstream over a valid/ready handshake.
// When the result register is blocked, the finished value is parked in acc
// (HOLD) and in_ready drops, back-pressuring the address generator.
//
// Optional feature macro: ZZACC_SAT_EN
//   defined   - every accumulation step saturates to the BWACC signed range
//   undefined - two's-complement wrap to BWACC bits
// Either way, the overflow flag records that the true value left the range.
//
// Ports:
//   clk        clock, rising edge
//   clr        synchronous active-high reset
//   in_valid   beat present
//   in_ready   beat accepted when in_valid & in_ready (low only in HOLD)
//   in_data    signed partial sum of one bit-plane pair (BWIN bits)
//   in_sh      shift flag from generator, aligned with in_data
//   in_neg     subtract the term (sign-plane product)
//   in_last    final beat of this multiplication
//   out_valid  result register full
//   out_ready  consumer takes result when out_valid & out_ready
//   out_data   signed result (BWACC bits)
//   out_ovf    overflow occurred while forming out_data
//   busy       state != IDLE or out_valid
module zzacc #(
  parameter int BWIN  = 27,
  parameter int BWACC = 32
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [BWIN-1:0]  in_data,
  input  logic                    in_sh,
  input  logic                    in_neg,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [BWACC-1:0] out_data,
  output logic                    out_ovf,
  output logic                    busy
);

  // Two guard bits: enough for (acc << 1) + term without losing the true sign.
  localparam int W = BWACC + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [BWACC-1:0]  acc_q, acc_d;
  logic                     ovf_acc_q, ovf_acc_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [BWACC-1:0]  out_data_q, out_data_d;
  logic                     out_ovf_q, out_ovf_d;

  logic signed [W-1:0]      term_ext;
  logic signed [W-1:0]      term_w;
  logic signed [W-1:0]      base_w;
  logic signed [W-1:0]      sum_w;
  logic [2:0]               top_bits;
  logic                     step_ovf;
  logic signed [BWACC-1:0]  step_val;
  logic                     ovf_next;
  logic                     fire;
  logic                     out_free;

  // Datapath for one accepted beat. In IDLE the base is zero, so the same
  // adder loads the first term; ovf_acc restarts from the step flag alone.
  always_comb begin
    term_ext = {{(W-BWIN){in_data[BWIN-1]}}, in_data};
    term_w   = in_neg ? -term_ext : term_ext;
    if (state_q == ACC) begin
      base_w = in_sh ? {acc_q[BWACC-1], acc_q, 1'b0}
                     : {{2{acc_q[BWACC-1]}}, acc_q};
    end else begin
      base_w = '0;
    end
    sum_w    = base_w + term_w;
    // In range only if the guard bits and the result sign bit all agree.
    top_bits = sum_w[W-1:BWACC-1];
    step_ovf = (top_bits != 3'b000) && (top_bits != 3'b111);
`ifdef ZZACC_SAT_EN
    if (step_ovf) begin
      step_val = sum_w[W-1] ? {1'b1, {(BWACC-1){1'b0}}}
                            : {1'b0, {(BWACC-1){1'b1}}};
    end else begin
      step_val = sum_w[BWACC-1:0];
    end
`else
    step_val = sum_w[BWACC-1:0];
`endif
    ovf_next = ((state_q == ACC) ? ovf_acc_q : 1'b0) | step_ovf;
  end

  assign in_ready = (state_q != HOLD);
  assign fire     = in_valid & in_ready;
  // Register can accept a new value if empty or being drained this cycle.
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE, ACC: begin
        if (fire) begin
          acc_d     = step_val;
          ovf_acc_d = ovf_next;
          if (in_last) begin
            if (out_free) begin
              out_valid_d = 1'b1;
              out_data_d  = step_val;
              out_ovf_d   = ovf_next;
              state_d     = IDLE;
            end else begin
              state_d = HOLD;
            end
          end else begin
            state_d = ACC;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_q;
          out_ovf_d   = ovf_acc_q;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (state_q != IDLE) | out_valid_q;

endmodule
